stopwatch_ctrl: RTL and testbench

//   Control sequencer for the stopwatch BCD counter chain (mm:ss:cc).
//   - Cleans up three raw pushbuttons.
//   - Derives the centisecond count strobe from the system clock.
//   - Runs the IDLE/RUN/PAUSE/LAP/FULL state machine.
//   - Drives count-enable, clear, lap-capture and display-hold into the counter and display path.

---
 rtl/stopwatch_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button clean-up, centisecond strobe generation
// and the IDLE/RUN/PAUSE/LAP/FULL state machine driving the mm:ss:cc BCD chain.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped at zero; start begins counting, clear re-zeroes
// RUN   | counting, display shows live count
// PAUSE | counting suspended, prescaler phase retained
// LAP   | counting continues, display frozen on the lap register
// FULL  | chain saturated at 59:59.99; only clear leaves
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic [2:0] state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  // Button lane indices within the packed button vectors.
  localparam int BI_START = 0;
  localparam int BI_LAP   = 1;
  localparam int BI_CLEAR = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  logic [2:0]      btn_raw;
  logic [2:0]      btn_meta;
  logic [2:0]      btn_sync;
  logic [2:0]      btn_level;
  logic [2:0]      btn_level_q;
  logic [2:0]      btn_press;
  logic [DB_W-1:0] db_cnt [3];

  logic [PRE_W-1:0] presc;

  state_t state_q;
  state_t state_nxt;
  logic   clr_nxt;
  logic   lap_nxt;

  logic ev_clear;
  logic ev_start;
  logic ev_lap;
  logic counting;
  logic active;
  logic tick;
  logic full_hit;

  assign btn_raw = {btn_clear, btn_lap, btn_start};

  // Two-flop synchronizer on the raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: a level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_level   <= '0;
      btn_level_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_level_q <= btn_level;
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= btn_sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_press = btn_level & ~btn_level_q;

  // Same-cycle events resolve as clear > start > lap; losers are dropped.
  assign ev_clear = btn_press[BI_CLEAR];
  assign ev_start = btn_press[BI_START] & ~btn_press[BI_CLEAR];
  assign ev_lap   = btn_press[BI_LAP] & ~btn_press[BI_START] & ~btn_press[BI_CLEAR];

  // A start press while counting freezes the prescaler in the same cycle, so a
  // strobe never lands in PAUSE and the pending partial period survives resume.
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign active   = counting & ~ev_start;
  assign tick     = active & (presc == PRE_LAST);
  assign full_hit = tick & cnt_max;

  // Prescaler: advances while counting, holds otherwise, zeroed with every clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clr_nxt) begin
      presc <= '0;
    end else if (active) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Next-state and next-pulse decode.
  always_comb begin
    state_nxt = state_q;
    clr_nxt   = 1'b0;
    lap_nxt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_clear) begin
          clr_nxt = 1'b1;
        end else if (ev_start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (ev_start) begin
          state_nxt = S_PAUSE;
        end else if (full_hit) begin
          state_nxt = S_FULL;
        end else if (ev_lap) begin
          state_nxt = S_LAP;
          lap_nxt   = 1'b1;
        end
      end
      S_LAP: begin
        if (ev_start) begin
          state_nxt = S_PAUSE;
        end else if (full_hit) begin
          state_nxt = S_FULL;
        end else if (ev_lap) begin
          state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ev_clear) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else if (ev_start) begin
          state_nxt = S_RUN;
        end
      end
      S_FULL: begin
        if (ev_clear) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      lap_load  <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_en    <= tick & ~cnt_max;
      cnt_clr   <= clr_nxt;
      lap_load  <= lap_nxt;
      disp_hold <= (state_nxt == S_LAP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at DIV=10, DB_CYCLES=4. A reference model derives
// expected output events from the raw-button history; a monitor compares them.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;
  localparam int DB  = 4;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_LAP = 3, ST_FULL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0, cnt_max = 1'b0;
  logic       cnt_en, cnt_clr, lap_load, disp_hold;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;
  exp_t exp_q[$];

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(rst_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .cnt_max(cnt_max),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_load(lap_load),
    .disp_hold(disp_hold), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       hist [3][8];   // hist[b][n] = raw button b sampled n edges ago
  logic [2:0] m_lvl, m_lvl_prev;
  int         m_flip [3];    // edge index of the last accepted level change
  int         m_st, m_act;   // m_act = active counting cycles since last clear
  logic [6:0] m_prev;

  always @(posedge clk) begin
    logic [2:0] raw, prs;
    logic ev_c, ev_s, ev_l, act, tck, full, n_en, n_clr, n_lap, all_diff;
    logic [6:0] vec;
    int nst;
    cyc++;
    raw = {btn_clear, btn_lap, btn_start};
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        for (int n = 0; n < 8; n++) hist[b][n] = 1'b0;
        m_flip[b] = cyc;
      end
      m_lvl = '0; m_lvl_prev = '0; m_st = ST_IDLE; m_act = 0; m_prev = '0;
    end else begin
      prs  = m_lvl & ~m_lvl_prev;
      ev_c = prs[2];
      ev_s = prs[0] && !prs[2];
      ev_l = prs[1] && !prs[0] && !prs[2];
      act  = (m_st == ST_RUN || m_st == ST_LAP) && !ev_s;
      tck  = act && (m_act % DIV == DIV - 1);
      full = tck && cnt_max;
      n_en = tck && !cnt_max;
      n_clr = 1'b0; n_lap = 1'b0; nst = m_st;
      if (m_st == ST_IDLE) begin
        if (ev_c) n_clr = 1'b1;
        else if (ev_s) nst = ST_RUN;
      end else if (m_st == ST_RUN) begin
        if (ev_s) nst = ST_PAUSE;
        else if (full) nst = ST_FULL;
        else if (ev_l) begin nst = ST_LAP; n_lap = 1'b1; end
      end else if (m_st == ST_LAP) begin
        if (ev_s) nst = ST_PAUSE;
        else if (full) nst = ST_FULL;
        else if (ev_l) nst = ST_RUN;
      end else if (m_st == ST_PAUSE) begin
        if (ev_c) begin nst = ST_IDLE; n_clr = 1'b1; end
        else if (ev_s) nst = ST_RUN;
      end else begin
        if (ev_c) begin nst = ST_IDLE; n_clr = 1'b1; end
      end
      if (act) m_act++;
      if (n_clr) m_act = 0;
      m_st = nst;
      vec = {3'(nst), (nst == ST_LAP), n_en, n_clr, n_lap};
      if (vec != m_prev || vec[2:0] != 3'b000) exp_q.push_back('{cyc, vec});
      m_prev = vec;
      // Accept a new level once the last DB synchronized samples (raw delayed
      // by two edges) all disagree with it and none predate the last change.
      for (int b = 0; b < 3; b++) begin
        for (int n = 7; n > 0; n--) hist[b][n] = hist[b][n-1];
        hist[b][0] = raw[b];
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (hist[b][j+2] == m_lvl[b] || cyc - j <= m_flip[b]) all_diff = 1'b0;
        m_lvl_prev[b] = m_lvl[b];
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_flip[b] = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [6:0] dv;
    logic [6:0] dprev;
    exp_t e;
    #2;
    if (!rst_n) begin
      dprev = '0;
    end else begin
      dv = {state, disp_hold, cnt_en, cnt_clr, lap_load};
      if (dv != dprev || dv[2:0] != 3'b000) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected cyc=%0d got vec=%b, no event expected", cyc, dv);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec != dv) begin
            bad++;
            $display("FAIL sb_event cyc=%0d got vec=%b expected vec=%b at cyc=%0d",
                     cyc, dv, e.vec, e.cyc);
          end
        end
      end
      dprev = dv;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [2:0] m, input int hold, input int gap);
    {btn_clear, btn_lap, btn_start} = m;
    repeat (hold) @(negedge clk);
    {btn_clear, btn_lap, btn_start} = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_cnt_en"}, cnt_en, 0);
    chk({tag, "_cnt_clr"}, cnt_clr, 0);
    chk({tag, "_lap_load"}, lap_load, 0);
    chk({tag, "_disp_hold"}, disp_hold, 0);
  endtask

  initial begin
    int n, cnt;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Short glitches must never be accepted.
    for (int i = 0; i < 4; i++) press(3'b001, 2 + (i % 2), 6);
    chk("glitch_idle", state, ST_IDLE);

    // Start held: RUN seven edges after the press, then one strobe per DIV.
    btn_start = 1'b1;
    n = 0;
    while (n < 20 && state != 3'(ST_RUN)) begin
      @(posedge clk); #1; n++;
    end
    chk("start_latency", n, 7);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(posedge clk); #1; cnt += int'(cnt_en);
    end
    chk("run_rate", cnt, 5);
    @(negedge clk);

    // Pause with a partial period pending, then resume.
    n = 0;
    while (n < 40 && !(m_st == ST_RUN && m_act % DIV == 6)) begin
      @(negedge clk); n++;
    end
    chk("presc6_found", int'(n < 40), 1);
    press(3'b001, 6, 10);
    chk("paused", state, ST_PAUSE);
    repeat (50) @(negedge clk);
    press(3'b001, 6, 20);
    chk("resumed", state, ST_RUN);

    // Lap in and out.
    press(3'b010, 6, 5);
    chk("lap_hold", disp_hold, 1);
    repeat (20) @(negedge clk);
    press(3'b010, 6, 10);
    chk("lap_release", state, ST_RUN);

    // Saturation, start ignored in FULL, clear back to IDLE.
    cnt_max = 1'b1;
    n = 0;
    while (n < 30 && state != 3'(ST_FULL)) begin
      @(negedge clk); n++;
    end
    chk("full_reached", state, ST_FULL);
    press(3'b001, 6, 10);
    chk("full_start_ignored", state, ST_FULL);
    press(3'b100, 6, 10);
    chk("full_cleared", state, ST_IDLE);
    cnt_max = 1'b0;

    // Clear beats start from PAUSE; reset mid-LAP.
    press(3'b001, 6, 10);
    press(3'b001, 6, 10);
    chk("pause_again", state, ST_PAUSE);
    press(3'b101, 6, 10);
    chk("clear_wins", state, ST_IDLE);
    press(3'b001, 6, 10);
    press(3'b010, 6, 5);
    chk("in_lap", state, ST_LAP);
    rst_n = 1'b0;
    #1;
    chk_zero("midlap_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized presses, glitches, saturation and occasional resets.
    for (int i = 0; i < 250; i++) begin
      cnt_max = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_reset_state", state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
      end
      press(3'($urandom_range(0, 7)), $urandom_range(1, 9), $urandom_range(0, 12));
    end
    cnt_max = 1'b0;

    repeat (20) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
